// File: rtl/rr_arbiter4.sv
// rr_arbiter4: four-requester round-robin arbiter with tenure hold limit.
//
// Ports:
//   clk               single clock, all logic on posedge
//   rstn              synchronous active-low reset
//   req0..req3        level requests, held until end of tenure
//   eot0..eot3        end-of-transfer pulses; only the current owner's is honoured
//   gnt0..gnt3        registered grants, one-hot or zero
//   busy              registered, high while any grant is high
//   timeout           registered one-cycle pulse when a tenure is cut by the hold limit
//
// Parameter:
//   MAX_HOLD          maximum cycles a grant may be held (2..65535)

module rr_arbiter4 #(
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic clk,
  input  logic rstn,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  input  logic eot0,
  input  logic eot1,
  input  logic eot2,
  input  logic eot3,
  output logic gnt0,
  output logic gnt1,
  output logic gnt2,
  output logic gnt3,
  output logic busy,
  output logic timeout
);

  localparam int unsigned CW = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LIMIT = CW'(MAX_HOLD);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] OWN  = 1'b1;

  logic [3:0]    req;
  logic [3:0]    eot;
  logic [0:0]    state_q, state_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    last_q, last_d;   // doubles as the owner index while in OWN
  logic [CW-1:0] hold_q, hold_d;
  logic          busy_q, busy_d;
  logic          timeout_q, timeout_d;

  logic          win_valid;
  logic [1:0]    win_idx;
  logic [1:0]    idx;
  logic          rel_eot, rel_abort, rel_hold;

  assign req = {req3, req2, req1, req0};
  assign eot = {eot3, eot2, eot1, eot0};

  // Round-robin search starting just after the last winner.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = 2'd0;
    idx       = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last_q + 2'(k);
      if (!win_valid && req[idx]) begin
        win_valid = 1'b1;
        win_idx   = idx;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    rel_eot   = eot[last_q];
    rel_abort = !req[last_q];
    rel_hold  = (hold_q == HOLD_LIMIT);

    case (state_q)
      IDLE: begin
        gnt_d = 4'b0000;
        if (win_valid) begin
          state_d = OWN;
          gnt_d   = 4'b0001 << win_idx;
          last_d  = win_idx;
          hold_d  = CW'(1);
        end
      end
      default: begin
        if (rel_eot || rel_abort || rel_hold) begin
          state_d   = IDLE;
          gnt_d     = 4'b0000;
          // eot/abort take precedence over the hold limit.
          timeout_d = rel_hold && !rel_eot && !rel_abort;
        end else if (hold_q != HOLD_LIMIT) begin
          hold_d = hold_q + CW'(1);
        end
      end
    endcase

    busy_d = |gnt_d;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      last_q    <= 2'd3;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt0    = gnt_q[0];
  assign gnt1    = gnt_q[1];
  assign gnt2    = gnt_q[2];
  assign gnt3    = gnt_q[3];
  assign busy    = busy_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4: directed scenarios plus randomized run against a tenure-level model.

module tb_rr_arbiter4;

  localparam int unsigned MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] req_v;
  logic [3:0] eot_v;
  logic [3:0] gnt;
  logic       busy;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who owns the bus, whose turn was last, tenure length so far.
  int         m_owner;
  int         m_last;
  int         m_hold;
  logic [3:0] m_gnt;
  logic       m_to;

  always #5 clk = ~clk;

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rstn(rstn),
    .req0(req_v[0]), .req1(req_v[1]), .req2(req_v[2]), .req3(req_v[3]),
    .eot0(eot_v[0]), .eot1(eot_v[1]), .eot2(eot_v[2]), .eot3(eot_v[3]),
    .gnt0(gnt[0]), .gnt1(gnt[1]), .gnt2(gnt[2]), .gnt3(gnt[3]),
    .busy(busy), .timeout(timeout)
  );

  function automatic void model_step();
    m_to = 1'b0;
    if (!rstn) begin
      m_owner = -1;
      m_last  = 3;
      m_hold  = 0;
    end else if (m_owner < 0) begin
      for (int k = 1; k <= 4; k++) begin
        if (m_owner < 0 && req_v[(m_last + k) % 4]) begin
          m_owner = (m_last + k) % 4;
          m_last  = m_owner;
          m_hold  = 1;
        end
      end
    end else begin
      if (eot_v[m_owner] || !req_v[m_owner]) begin
        m_owner = -1;
      end else if (m_hold >= int'(MAX_HOLD)) begin
        m_owner = -1;
        m_to    = 1'b1;
      end else begin
        m_hold++;
      end
    end
    m_gnt = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn  = 1'b0;
    req_v = 4'b1111;
    eot_v = 4'b0000;
    tick();
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: gnt=%b busy=%b timeout=%b want 0000/0/0", gnt, busy, timeout);
    end
  endtask

  // Fresh reset with all four requesting: grant order 0,1,2,3,0, two cycles each.
  task automatic test_rr_sequence();
    int order [5] = '{0, 1, 2, 3, 0};
    rstn = 1'b1;
    for (int t = 0; t < 5; t++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'(1 << order[t]) || busy !== 1'b1) begin
        n_err++;
        $display("FAIL rr_grant%0d: gnt=%b busy=%b want %b/1", t, gnt, busy, 4'(1 << order[t]));
      end
      tick();
      n_cmp++;
      if (gnt !== 4'(1 << order[t])) begin
        n_err++;
        $display("FAIL rr_hold%0d: gnt=%b want %b", t, gnt, 4'(1 << order[t]));
      end
      eot_v[order[t]] = 1'b1;
      tick();
      eot_v = 4'b0000;
      n_cmp++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || timeout !== 1'b0) begin
        n_err++;
        $display("FAIL rr_gap%0d: gnt=%b busy=%b to=%b want 0000/0/0", t, gnt, busy, timeout);
      end
    end
    req_v = 4'b0000;
    tick();
  endtask

  task automatic test_single_requester();
    req_v = 4'b0100;
    for (int t = 0; t < 3; t++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0100 || busy !== 1'b1) begin
        n_err++;
        $display("FAIL single_grant%0d: gnt=%b busy=%b want 0100/1", t, gnt, busy);
      end
      eot_v = 4'b0100;
      tick();
      eot_v = 4'b0000;
      n_cmp++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL single_gap%0d: gnt=%b busy=%b want 0000/0", t, gnt, busy);
      end
    end
    req_v = 4'b0000;
    tick();
  endtask

  // Owner 1 never signals eot: four grant cycles, then a gap with timeout, then re-grant.
  task automatic test_timeout();
    req_v = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0010 || timeout !== 1'b0) begin
        n_err++;
        $display("FAIL hold_cycle%0d: gnt=%b to=%b want 0010/0", c, gnt, timeout);
      end
    end
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b1) begin
      n_err++;
      $display("FAIL timeout_pulse: gnt=%b to=%b want 0000/1", gnt, timeout);
    end
    tick();
    n_cmp++;
    if (gnt !== 4'b0010 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_regrant: gnt=%b to=%b want 0010/0", gnt, timeout);
    end
    // eot on the limit edge suppresses the timeout pulse.
    for (int c = 0; c < 3; c++) tick();
    eot_v = 4'b0010;
    tick();
    eot_v = 4'b0000;
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL timeout_suppress: gnt=%b to=%b want 0000/0", gnt, timeout);
    end
    req_v = 4'b0000;
    tick();
  endtask

  task automatic test_foreign_eot_abort();
    eot_v = 4'b1000;
    tick();
    eot_v = 4'b0000;
    req_v = 4'b0001;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL own_grant0: gnt=%b want 0001", gnt);
    end
    eot_v = 4'b1000;
    tick();
    eot_v = 4'b0000;
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL foreign_eot: gnt=%b want 0001", gnt);
    end
    req_v = 4'b0000;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      n_err++;
      $display("FAIL abort_release: gnt=%b to=%b want 0000/0", gnt, timeout);
    end
  endtask

  task automatic test_reset_mid_tenure();
    req_v = 4'b0100;
    tick();
    tick();
    n_cmp++;
    if (gnt !== 4'b0100) begin
      n_err++;
      $display("FAIL mid_setup: gnt=%b want 0100", gnt);
    end
    req_v = 4'b1111;
    rstn  = 1'b0;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || timeout !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: gnt=%b to=%b busy=%b want 0000/0/0", gnt, timeout, busy);
    end
    rstn = 1'b1;
    tick();
    n_cmp++;
    if (gnt !== 4'b0001) begin
      n_err++;
      $display("FAIL post_reset_grant: gnt=%b want 0001", gnt);
    end
    req_v = 4'b0000;
    tick();
  endtask

  task automatic test_random();
    int         waits [4];
    logic [3:0] prev_gnt;
    rstn  = 1'b0;
    req_v = 4'b0000;
    eot_v = 4'b0000;
    tick();
    rstn = 1'b1;
    for (int i = 0; i < 4; i++) waits[i] = 0;
    prev_gnt = 4'b0000;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(7) == 0) req_v[i] = ~req_v[i];
        eot_v[i] = ($urandom_range(5) == 0);
        if (!req_v[i]) waits[i] = 0;
      end
      tick();
      n_cmp++;
      if (gnt !== m_gnt || busy !== (|m_gnt) || timeout !== m_to) begin
        n_err++;
        $display("FAIL rand_c%0d: gnt=%b busy=%b to=%b want %b/%b/%b",
                 cyc, gnt, busy, timeout, m_gnt, |m_gnt, m_to);
      end
      n_cmp++;
      if ((gnt & (gnt - 4'd1)) !== 4'b0000) begin
        n_err++;
        $display("FAIL rand_onehot%0d: gnt=%b want one-hot or zero", cyc, gnt);
      end
      if (prev_gnt == 4'b0000 && gnt != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (gnt[i]) waits[i] = 0;
          else if (req_v[i]) waits[i]++;
          n_cmp++;
          if (waits[i] > 3) begin
            n_err++;
            $display("FAIL starve%0d_c%0d: waited %0d tenures want <= 3", i, cyc, waits[i]);
          end
        end
      end
      prev_gnt = gnt;
    end
  endtask

  initial begin
    m_owner = -1;
    m_last  = 3;
    m_hold  = 0;
    m_gnt   = 4'b0000;
    m_to    = 1'b0;
    test_reset();
    test_rr_sequence();
    test_single_requester();
    test_timeout();
    test_foreign_eot_abort();
    test_reset_mid_tenure();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_arbiter4.md
RR_ARBITER4 -- requirements
Module: rr_arbiter4

Parameters
REQ-001 SHALL provide parameter MAX_HOLD, default 64; meaning: maximum cycles a grant may be held before forced release (range 2..65535).

Interface
REQ-002 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port rstn  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports req0..req3  input  1 each  request from requester 0..3, level, held until end of tenure.
REQ-005 SHALL have ports eot0..eot3  input  1 each  end-of-transfer pulse from requester 0..3.
REQ-006 SHALL have ports gnt0..gnt3  output  1 each  grant to requester 0..3, registered.
REQ-007 SHALL have port busy  output  1  high while any gnt is high, registered.
REQ-008 SHALL have port timeout  output  1  one-cycle pulse on forced release, registered.

Function
REQ-009 SHALL assert at most one gnt in any cycle (one-hot or zero).
REQ-010 SHALL implement states IDLE and OWN; reset state IDLE.
REQ-011 SHALL, in IDLE with any req high at posedge, grant the winner at that edge: gnt rises in the following cycle; latency req->gnt = 1 clock.
REQ-012 SHALL choose the winner round-robin: search starts at index (last+1) mod 4 and increments mod 4; first high req wins.
REQ-013 SHALL update last to the winner's index when the grant is issued.
REQ-014 SHALL remain in IDLE with all gnt low when no req is high.
REQ-015 SHALL, in OWN, hold gnt of owner i stable until a release event.
REQ-016 SHALL treat each of the following as a release event for owner i: eot_i high at a posedge; req_i low at a posedge (abort); hold counter reaching MAX_HOLD.
REQ-017 SHALL, on a release event, drop gnt_i at that edge and enter IDLE; gnt stays all-low for exactly one cycle before any new grant.
REQ-018 SHALL ignore eot_j when j is not the current owner, including in IDLE.
REQ-019 SHALL run a hold counter: cleared to 1 when a grant is issued, incremented each OWN cycle, width ceil(log2(MAX_HOLD+1)), saturating, never wrapping.
REQ-020 SHALL pulse timeout for exactly one cycle, coincident with the first all-low gnt cycle, when release is due only to the hold counter; eot or abort on the same edge takes precedence and suppresses timeout.
REQ-021 SHALL, when the releasing owner still requests, give it lowest priority in the next arbitration; if it is the only requester, re-grant it after the one-cycle gap.
REQ-022 SHALL sample req changes during OWN without effect on gnt; only the state at the arbitration edge counts.
REQ-023 SHALL drive busy equal to OR of gnt0..gnt3 in the same cycle.
REQ-024 SHALL guarantee that each continuously requesting master receives a grant within 3 tenures of another master.

Reset
REQ-025 SHALL, on rstn low at a posedge, force gnt0..gnt3 = 0, busy = 0, timeout = 0, state IDLE, hold counter 0, and last = 3 (req0 highest priority first).
REQ-026 SHALL apply reset mid-tenure by dropping gnt on the next cycle with no timeout pulse.
REQ-027 SHALL not issue a grant at the edge where rstn is low; arbitration resumes at the first posedge with rstn high.

Verification
REQ-028 Reset release, req0..req3 = 1111 -> gnt sequence 0,1,2,3,0 with eot after 2 cycles each; one all-low cycle between grants.
REQ-029 Only req2 high, eot2 every tenure -> gnt2 re-granted each time, pattern 1 cycle low between tenures, busy tracks gnt2.
REQ-030 Owner 1 holds with no eot, MAX_HOLD = 4 -> gnt1 high 4 cycles, then low with timeout = 1 for one cycle.
REQ-031 Owner 0 granted, eot3 pulsed -> gnt0 unaffected; then req0 dropped -> gnt0 falls next edge, no timeout.
REQ-032 rstn low during gnt2 tenure -> all gnt low next cycle, after release first grant to lowest index request (req0 wins if high).
REQ-033 Random req/eot for 10000 cycles -> one-hot-or-zero gnt each cycle, no starvation beyond REQ-024 bound.
